// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers, SCL edge and START/STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // START/STOP need SCL high on both sides of the SDA transition
    assign sda_s     = sda_sync;
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C slave with single-byte receive and streamed transmit.
module i2c_slave #(
    parameter logic [6:0] ADDRESS = 7'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       addressed,
    output logic       read_nwrite,
    output logic       newData,
    output logic [7:0] data_o,
    output logic       dataReq,
    input  logic [7:0] data_i
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_RX       = 3'd3;
    localparam logic [2:0] ST_RX_ACK   = 3'd4;
    localparam logic [2:0] ST_TX       = 3'd5;
    localparam logic [2:0] ST_TX_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx, data_o_nx;
    logic       byte_done, byte_done_nx;
    logic       sda_low, sda_low_nx;
    logic       busy_nx, addressed_nx, rnw_nx, new_data_nx, data_req_nx;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (SCL),
        .sda       (SDA),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign SDA = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            byte_done   <= 1'b0;
            sda_low     <= 1'b0;
            busy        <= 1'b0;
            addressed   <= 1'b0;
            read_nwrite <= 1'b0;
            newData     <= 1'b0;
            dataReq     <= 1'b0;
            data_o      <= 8'h00;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            shreg       <= shreg_nx;
            byte_done   <= byte_done_nx;
            sda_low     <= sda_low_nx;
            busy        <= busy_nx;
            addressed   <= addressed_nx;
            read_nwrite <= rnw_nx;
            newData     <= new_data_nx;
            dataReq     <= data_req_nx;
            data_o      <= data_o_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shreg_nx     = shreg;
        byte_done_nx = byte_done;
        sda_low_nx   = sda_low;
        busy_nx      = busy;
        addressed_nx = addressed;
        rnw_nx       = read_nwrite;
        data_o_nx    = data_o;
        new_data_nx  = 1'b0;
        data_req_nx  = 1'b0;

        if (stop_det) begin
            state_nx     = ST_IDLE;
            bit_cnt_nx   = 3'd0;
            byte_done_nx = 1'b0;
            sda_low_nx   = 1'b0;
            busy_nx      = 1'b0;
            addressed_nx = 1'b0;
            rnw_nx       = 1'b0;
        end else if (start_det) begin
            state_nx     = ST_ADDR;
            bit_cnt_nx   = 3'd0;
            byte_done_nx = 1'b0;
            sda_low_nx   = 1'b0;
            busy_nx      = 1'b1;
            addressed_nx = 1'b0;
            rnw_nx       = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_nx   = {shreg[6:0], sda_s};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_nx = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_nx = 1'b0;
                        if (shreg[7:1] == ADDRESS) begin
                            state_nx     = ST_ADDR_ACK;
                            sda_low_nx   = 1'b1;
                            addressed_nx = 1'b1;
                            rnw_nx       = shreg[0];
                        end else begin
                            state_nx = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && read_nwrite) begin
                        data_req_nx = 1'b1;
                    end else if (scl_fall) begin
                        // a read hands over straight into bit 7 of the first byte
                        if (read_nwrite) begin
                            state_nx   = ST_TX;
                            shreg_nx   = {data_i[6:0], 1'b0};
                            sda_low_nx = ~data_i[7];
                        end else begin
                            state_nx   = ST_RX;
                            sda_low_nx = 1'b0;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shreg_nx   = {shreg[6:0], sda_s};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            data_o_nx    = {shreg[6:0], sda_s};
                            new_data_nx  = 1'b1;
                            byte_done_nx = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nx = 1'b0;
                        sda_low_nx   = 1'b1;
                        state_nx     = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_low_nx = 1'b0;
                        state_nx   = ST_RX;
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_nx = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            byte_done_nx = 1'b0;
                            sda_low_nx   = 1'b0;
                            state_nx     = ST_TX_ACK;
                        end else begin
                            sda_low_nx = ~shreg[7];
                            shreg_nx   = {shreg[6:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    // byte_done here marks "master ACKed, load next byte on the fall"
                    if (scl_rise) begin
                        if (!sda_s) begin
                            data_req_nx  = 1'b1;
                            byte_done_nx = 1'b1;
                        end else begin
                            sda_low_nx = 1'b0;
                            state_nx   = ST_IGNORE;
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nx = 1'b0;
                        state_nx     = ST_TX;
                        shreg_nx     = {data_i[6:0], 1'b0};
                        sda_low_nx   = ~data_i[7];
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_low_nx = 1'b0;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench driving i2c_slave through a behavioural bus master.
module tb_i2c_slave;

    localparam logic [1:0] RATE = 2'b01;
    localparam int         QTR  = 10 * (int'(RATE) + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] data_i = 8'h00;
    wire        sda_bus;
    logic       busy, addressed, read_nwrite, newData, dataReq;
    logic [7:0] data_o;

    int checks = 0;
    int errors = 0;
    int nd_cnt = 0, nd_cycles = 0, dr_cnt = 0, slave_low_cnt = 0, addr_hi_cnt = 0;
    int dr_base = 0;
    logic       nd_prev = 1'b0;
    logic [7:0] tx_data [4];

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave #(.ADDRESS(7'h40)) dut (
        .clk         (clk),
        .rst         (rst),
        .SCL         (m_scl),
        .SDA         (sda_bus),
        .busy        (busy),
        .addressed   (addressed),
        .read_nwrite (read_nwrite),
        .newData     (newData),
        .data_o      (data_o),
        .dataReq     (dataReq),
        .data_i      (data_i)
    );

    always @(negedge clk) begin
        if (newData) nd_cycles++;
        if (newData && !nd_prev) nd_cnt++;
        nd_prev = newData;
        if (sda_bus === 1'b0 && !m_sda_low) slave_low_cnt++;
        if (addressed) addr_hi_cnt++;
        if (dataReq) begin
            data_i = tx_data[(dr_cnt - dr_base) % 4];
            dr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (QTR) @(posedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_q();
        m_scl = 1'b1;     wait_q();
        m_sda_low = 1'b1; wait_q();
        m_scl = 1'b0;     wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        m_scl = 1'b1;     wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda_low = ~b; wait_q();
        m_scl = 1'b1;   wait_q();
        r = sda_bus;    wait_q();
        m_scl = 1'b0;   wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        int         nd0, dr0, sl0, ah0;

        tx_data[0] = 8'hC3; tx_data[1] = 8'h00; tx_data[2] = 8'hFF; tx_data[3] = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_addressed", 32'(addressed), 32'h0);
        check("rst_rnw", 32'(read_nwrite), 32'h0);
        check("rst_newdata", 32'(newData), 32'h0);
        check("rst_datareq", 32'(dataReq), 32'h0);
        check("rst_data_o", 32'(data_o), 32'h00);
        check("rst_sda", 32'(sda_bus), 32'h1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        nd0 = nd_cnt;
        bus_start();
        write_byte(8'h80, ack);
        check("a_addr_ack", 32'(ack), 32'h1);
        check("a_addressed", 32'(addressed), 32'h1);
        check("a_rnw", 32'(read_nwrite), 32'h0);
        write_byte(8'hA5, ack);
        check("a_data_ack", 32'(ack), 32'h1);
        check("a_nd_pulses", 32'(nd_cnt - nd0), 32'd1);
        check("a_nd_cycles", 32'(nd_cycles - nd0), 32'd1);
        check("a_data_o", 32'(data_o), 32'hA5);
        check("a_busy", 32'(busy), 32'h1);
        bus_stop();
        repeat (4) @(negedge clk);
        check("a_busy_stop", 32'(busy), 32'h0);
        check("a_addr_stop", 32'(addressed), 32'h0);

        nd0 = nd_cnt;
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'h12, ack);
        check("b_ack1", 32'(ack), 32'h1);
        write_byte(8'h34, ack);
        check("b_ack2", 32'(ack), 32'h1);
        bus_stop();
        check("b_nd_pulses", 32'(nd_cnt - nd0), 32'd2);
        check("b_data_o", 32'(data_o), 32'h34);

        dr_base = dr_cnt;
        dr0 = dr_cnt;
        bus_start();
        write_byte(8'h81, ack);
        check("c_addr_ack", 32'(ack), 32'h1);
        check("c_rnw", 32'(read_nwrite), 32'h1);
        read_byte(1'b0, d);
        check("c_byte0", 32'(d), 32'hC3);
        read_byte(1'b0, d);
        check("c_byte1", 32'(d), 32'h00);
        read_byte(1'b1, d);
        check("c_byte2", 32'(d), 32'hFF);
        repeat (4) @(negedge clk);
        check("c_sda_released", 32'(sda_bus), 32'h1);
        bus_stop();
        check("c_dr_pulses", 32'(dr_cnt - dr0), 32'd3);

        nd0 = nd_cnt; dr0 = dr_cnt; sl0 = slave_low_cnt; ah0 = addr_hi_cnt;
        bus_start();
        write_byte(8'h82, ack);
        check("d_addr_nack", 32'(ack), 32'h0);
        write_byte(8'h55, ack);
        check("d_data_nack", 32'(ack), 32'h0);
        bus_stop();
        check("d_slave_low", 32'(slave_low_cnt - sl0), 32'd0);
        check("d_addressed", 32'(addr_hi_cnt - ah0), 32'd0);
        check("d_nd", 32'(nd_cnt - nd0), 32'd0);
        check("d_dr", 32'(dr_cnt - dr0), 32'd0);

        bus_start();
        write_byte(8'h80, ack);
        bit_xfer(1'b1, r);
        bit_xfer(1'b0, r);
        bit_xfer(1'b1, r);
        nd0 = nd_cnt;
        bus_start();
        write_byte(8'h80, ack);
        check("e_addr_ack", 32'(ack), 32'h1);
        check("e_data_o_kept", 32'(data_o), 32'h34);
        write_byte(8'h5A, ack);
        bus_stop();
        check("e_nd_pulses", 32'(nd_cnt - nd0), 32'd1);
        check("e_data_o", 32'(data_o), 32'h5A);

        tx_data[0] = 8'h00;
        dr_base = dr_cnt;
        bus_start();
        write_byte(8'h81, ack);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
        repeat (4) @(negedge clk);
        check("f_slave_driving", 32'(sda_bus), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("f_sda", 32'(sda_bus), 32'h1);
        check("f_busy", 32'(busy), 32'h0);
        check("f_addressed", 32'(addressed), 32'h0);
        check("f_rnw", 32'(read_nwrite), 32'h0);
        check("f_data_o", 32'(data_o), 32'h00);
        check("f_newdata", 32'(newData), 32'h0);
        check("f_datareq", 32'(dataReq), 32'h0);
        sl0 = slave_low_cnt;
        for (int i = 0; i < 6; i++) bit_xfer(1'b1, r);
        bus_stop();
        check("f_quiet_after_rst", 32'(slave_low_cnt - sl0), 32'd0);
        bus_start();
        write_byte(8'h80, ack);
        check("f_fresh_ack", 32'(ack), 32'h1);
        write_byte(8'h77, ack);
        bus_stop();
        check("f_fresh_data", 32'(data_o), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
